// File: rtl/motion_pkg.sv
// Shared widths and FSM state encoding for the motion frame scheduler.
package motion_pkg;

  localparam int unsigned PIX_W = 10;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned Y_W   = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/motion_zone_acc.sv
// Per-zone motion accumulator: saturating pixel count plus min/max row of
// motion pixels, with the row centre presented combinationally.
module motion_zone_acc
  import motion_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             motion,
  input  logic [Y_W-1:0]   y,
  output logic [CNT_W-1:0] count,
  output logic [Y_W-1:0]   centre_c
);

  logic [Y_W-1:0] ymin;
  logic [Y_W-1:0] ymax;
  logic [Y_W:0]   sum_c;

  // Accumulate count and row extent; clear wins over a same-cycle strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ymin  <= '1;
      ymax  <= '0;
    end else if (clear) begin
      count <= '0;
      ymin  <= '1;
      ymax  <= '0;
    end else if (motion) begin
      if (count != '1) begin
        count <= count + CNT_W'(1);
      end
      if (y < ymin) begin
        ymin <= y;
      end
      if (y > ymax) begin
        ymax <= y;
      end
    end
  end

  // Row centre on one extra bit so the sum never overflows; empty zone reports 0
  always_comb begin
    sum_c    = {1'b0, ymin} + {1'b0, ymax};
    centre_c = (count == '0) ? '0 : Y_W'(sum_c >> 1);
  end

endmodule

// File: rtl/motion_frame_scheduler.sv
// Frame-differencing scheduler: reads the previous-frame pixel, thresholds
// |cur-prev|, writes the current pixel back and reports per-zone motion.
// Optional build macro: MOTION_ROI_EN adds a row window (roi_y_min/roi_y_max)
// sampled at start of frame; motion outside it is not counted.
module motion_frame_scheduler
  import motion_pkg::*;
#(
  parameter int unsigned      H_RES            = 640,
  parameter int unsigned      V_RES            = 480,
  parameter int unsigned      ADDR_W           = 19,
  parameter logic [PIX_W-1:0] MOTION_THRESHOLD = 10'd400,
  parameter logic [CNT_W-1:0] MIN_PIXELS       = 16'd64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
`ifdef MOTION_ROI_EN
  input  logic [Y_W-1:0]    roi_y_min,
  input  logic [Y_W-1:0]    roi_y_max,
`endif
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [PIX_W-1:0]  fb_rd_data,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [PIX_W-1:0]  fb_wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  left_count,
  output logic [CNT_W-1:0]  right_count,
  output logic [Y_W-1:0]    left_y,
  output logic [Y_W-1:0]    right_y,
  output logic              left_valid,
  output logic              right_valid
);

  localparam int unsigned X_W = (H_RES > 1) ? $clog2(H_RES) : 1;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [X_W-1:0]    x_cnt;
  logic [Y_W-1:0]    y_cnt;
  logic              primed;

  // Stage 0 decode
  logic              accept_c;
  logic              sof_c;
  logic              last_c;
  logic [ADDR_W-1:0] cur_addr_c;
  logic [X_W-1:0]    cur_x_c;
  logic [Y_W-1:0]    cur_y_c;
  logic              in_roi_c;

  // Stage 1 registers and decode
  logic              s1_valid;
  logic [PIX_W-1:0]  s1_pix;
  logic [ADDR_W-1:0] s1_addr;
  logic [X_W-1:0]    s1_x;
  logic [Y_W-1:0]    s1_y;
  logic              s1_roi;
  logic [PIX_W-1:0]  diff_c;
  logic              motion_c;
  logic              left_zone_c;
  logic              left_motion_c;
  logic              right_motion_c;

  logic [CNT_W-1:0]  left_acc_cnt;
  logic [CNT_W-1:0]  right_acc_cnt;
  logic [Y_W-1:0]    left_centre_c;
  logic [Y_W-1:0]    right_centre_c;

  // Accept decision and pixel coordinates; a sof pixel always restarts at pixel 0
  always_comb begin
    accept_c = 1'b0;
    if (pix_valid) begin
      if (state == ST_SCAN) begin
        accept_c = 1'b1;
      end else if (state == ST_IDLE) begin
        accept_c = pix_sof;
      end
    end
    sof_c      = accept_c & pix_sof;
    cur_addr_c = sof_c ? '0 : addr_cnt;
    cur_x_c    = sof_c ? '0 : x_cnt;
    cur_y_c    = sof_c ? '0 : y_cnt;
    last_c     = accept_c & (cur_x_c == X_W'(H_RES - 1)) & (cur_y_c == Y_W'(V_RES - 1));
  end

  assign fb_rd_en   = accept_c;
  assign fb_rd_addr = cur_addr_c;

`ifdef MOTION_ROI_EN
  logic [Y_W-1:0] roi_lo;
  logic [Y_W-1:0] roi_hi;
  logic [Y_W-1:0] roi_lo_c;
  logic [Y_W-1:0] roi_hi_c;

  // Row window is captured with the sof pixel and applies to that pixel too
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roi_lo <= '0;
      roi_hi <= '0;
    end else if (sof_c) begin
      roi_lo <= roi_y_min;
      roi_hi <= roi_y_max;
    end
  end

  // Window test for the pixel being accepted
  always_comb begin
    roi_lo_c = sof_c ? roi_y_min : roi_lo;
    roi_hi_c = sof_c ? roi_y_max : roi_hi;
    in_roi_c = (cur_y_c >= roi_lo_c) & (cur_y_c <= roi_hi_c);
  end
`else
  assign in_roi_c = 1'b1;
`endif

  // Stage 1: absolute difference against the previous frame and zone steering
  always_comb begin
    diff_c         = (s1_pix >= fb_rd_data) ? (s1_pix - fb_rd_data) : (fb_rd_data - s1_pix);
    motion_c       = s1_valid & primed & s1_roi & (diff_c > MOTION_THRESHOLD);
    left_zone_c    = s1_x < X_W'(H_RES / 2);
    left_motion_c  = motion_c & left_zone_c;
    right_motion_c = motion_c & ~left_zone_c;
  end

  assign fb_wr_en   = s1_valid;
  assign fb_wr_addr = s1_addr;
  assign fb_wr_data = s1_pix;

  motion_zone_acc u_left_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (sof_c),
    .motion   (left_motion_c),
    .y        (s1_y),
    .count    (left_acc_cnt),
    .centre_c (left_centre_c)
  );

  motion_zone_acc u_right_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (sof_c),
    .motion   (right_motion_c),
    .y        (s1_y),
    .count    (right_acc_cnt),
    .centre_c (right_centre_c)
  );

  // Frame FSM, pixel counters, stage-1 pipeline register and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_cnt    <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      primed      <= 1'b0;
      s1_valid    <= 1'b0;
      s1_pix      <= '0;
      s1_addr     <= '0;
      s1_x        <= '0;
      s1_y        <= '0;
      s1_roi      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      left_count  <= '0;
      right_count <= '0;
      left_y      <= '0;
      right_y     <= '0;
      left_valid  <= 1'b0;
      right_valid <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      s1_valid   <= accept_c;
      if (accept_c) begin
        s1_pix   <= pix_data;
        s1_addr  <= cur_addr_c;
        s1_x     <= cur_x_c;
        s1_y     <= cur_y_c;
        s1_roi   <= in_roi_c;
        addr_cnt <= cur_addr_c + ADDR_W'(1);
        if (cur_x_c == X_W'(H_RES - 1)) begin
          x_cnt <= '0;
          y_cnt <= cur_y_c + Y_W'(1);
        end else begin
          x_cnt <= cur_x_c + X_W'(1);
          y_cnt <= cur_y_c;
        end
      end
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            state <= last_c ? ST_FLUSH : ST_SCAN;
            busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (last_c) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state <= ST_REPORT;
        end
        ST_REPORT: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          frame_done  <= 1'b1;
          primed      <= 1'b1;
          left_count  <= left_acc_cnt;
          right_count <= right_acc_cnt;
          left_y      <= left_centre_c;
          right_y     <= right_centre_c;
          left_valid  <= left_acc_cnt >= MIN_PIXELS;
          right_valid <= right_acc_cnt >= MIN_PIXELS;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_frame_scheduler.sv
// Directed bench for motion_frame_scheduler on an 8x4 frame with a
// behavioural frame buffer; expected results are hand-computed per frame.
module tb_motion_frame_scheduler;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 4;
  localparam int unsigned AW   = 5;
  localparam int unsigned NPIX = H * V;
  localparam int KIND_A = 0;
  localparam int KIND_B = 1;
  localparam int KIND_C = 2;

  logic          clk;
  logic          reset;
  logic          pix_valid;
  logic          pix_sof;
  logic [9:0]    pix_data;
`ifdef MOTION_ROI_EN
  logic [8:0]    roi_y_min;
  logic [8:0]    roi_y_max;
`endif
  logic          fb_rd_en;
  logic [AW-1:0] fb_rd_addr;
  logic [9:0]    fb_rd_data;
  logic          fb_wr_en;
  logic [AW-1:0] fb_wr_addr;
  logic [9:0]    fb_wr_data;
  logic          busy;
  logic          frame_done;
  logic [15:0]   left_count;
  logic [15:0]   right_count;
  logic [8:0]    left_y;
  logic [8:0]    right_y;
  logic          left_valid;
  logic          right_valid;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int exp_wa   = 0;
  bit chk_pair  = 0;
  bit chk_wrseq = 0;
  bit arm_w     = 0;
  bit arm_seen  = 0;
  logic          prev_rd_en   = 1'b0;
  logic [AW-1:0] prev_rd_addr = '0;
  logic [9:0]    mem [NPIX];

  motion_frame_scheduler #(
    .H_RES      (H),
    .V_RES      (V),
    .ADDR_W     (AW),
    .MIN_PIXELS (16'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
`ifdef MOTION_ROI_EN
    .roi_y_min   (roi_y_min),
    .roi_y_max   (roi_y_max),
`endif
    .fb_rd_en    (fb_rd_en),
    .fb_rd_addr  (fb_rd_addr),
    .fb_rd_data  (fb_rd_data),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_data  (fb_wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .left_count  (left_count),
    .right_count (right_count),
    .left_y      (left_y),
    .right_y     (right_y),
    .left_valid  (left_valid),
    .right_valid (right_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer: read data appears one cycle after the read strobe
  always @(posedge clk) begin
    if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];
    if (fb_wr_en) mem[fb_wr_addr] <= fb_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Write-side monitor: frame_done count, write sequence, read/write pairing
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (!arm_w) arm_seen = 0;
    if (fb_wr_en) begin
      if (chk_pair)
        check("rd_wr_pair", 32'({prev_rd_en, prev_rd_addr}), 32'({1'b1, fb_wr_addr}));
      if (chk_wrseq) begin
        check("wr_seq_addr", 32'(fb_wr_addr), 32'(exp_wa));
        check("wr_seq_data", 32'(fb_wr_data), 32'd500);
        exp_wa++;
      end
      if (arm_w && !arm_seen) begin
        check("abort_wr_addr", 32'(fb_wr_addr), 32'd0);
        arm_seen = 1;
      end
    end
    prev_rd_en   = fb_rd_en;
    prev_rd_addr = fb_rd_addr;
  end

  function automatic logic [9:0] pix_val(input int kind, input int idx);
    int x;
    int y;
    x = idx % H;
    y = idx / H;
    case (kind)
      KIND_B:  pix_val = ((y == 1 || y == 2) && x < 4) ? 10'd1000 : 10'd500;
      KIND_C:  pix_val = (idx == 6) ? 10'd901 : (idx == 17) ? 10'd100 :
                         (idx == 29) ? 10'd900 : 10'd500;
      default: pix_val = 10'd500;
    endcase
  endfunction

  // Stream n pixels of a frame back to back, sof on the first
  task automatic send_frame(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
      pix_sof   = (i == 0);
      pix_data  = pix_val(kind, i);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame_done", 32'(frame_done), 32'd1);
  endtask

  task automatic check_results(input string t, input int lc, input int ly, input int lv,
                               input int rc, input int ry, input int rv);
    check({t, "_left_count"},  32'(left_count),  32'(lc));
    check({t, "_left_y"},      32'(left_y),      32'(ly));
    check({t, "_left_valid"},  32'(left_valid),  32'(lv));
    check({t, "_right_count"}, 32'(right_count), 32'(rc));
    check({t, "_right_y"},     32'(right_y),     32'(ry));
    check({t, "_right_valid"}, 32'(right_valid), 32'(rv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
`ifdef MOTION_ROI_EN
    roi_y_min = 9'd0;
    roi_y_max = 9'd511;
`endif
    for (int i = 0; i < int'(NPIX); i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy_wr", 32'({busy, fb_wr_en, fb_rd_en, frame_done}), 32'd0);
    check("rst_counts", 32'({left_count, right_count}), 32'd0);
    check("rst_misc", 32'({left_y, right_y, left_valid, right_valid}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // IDLE: pixel without sof is ignored
    @(posedge clk); #1;
    pix_valid = 1'b1;
    pix_data  = 10'd123;
    @(negedge clk);
    check("idle_ignore_rd", 32'(fb_rd_en), 32'd0);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    check("idle_ignore_busy", 32'(busy), 32'd0);

    // 1: first frame after reset, unprimed
    chk_wrseq = 1;
    send_frame(KIND_A, NPIX);
    @(negedge clk);
    check("scan_busy", 32'(busy), 32'd1);
    wait_done();
    check_results("t1", 0, 0, 0, 0, 0, 0);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk_wrseq = 0;
    check("t1_n_writes", 32'(exp_wa), 32'(NPIX));
    @(negedge clk);
    check("t1_done_pulse", 32'(frame_done), 32'd0);
    check("t1_done_once", 32'(done_cnt), 32'd1);

    // 2: repeat frame A, read/write pairing, drops during FLUSH/REPORT
    chk_pair = 1;
    send_frame(KIND_A, NPIX);
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    @(negedge clk);
    check("flush_drop", 32'(fb_rd_en), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("report_drop", 32'(fb_rd_en), 32'd0);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    wait_done();
    check_results("t2", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_pair = 0;

    // 3: frame B, motion in rows 1-2 of the left half
    send_frame(KIND_B, NPIX);
    wait_done();
    check_results("t3", 8, 1, 1, 0, 0, 0);

    // 4: back to A, then threshold boundary frame C
    send_frame(KIND_A, NPIX);
    wait_done();
    check_results("t4a", 8, 1, 1, 0, 0, 0);
    send_frame(KIND_C, NPIX);
    wait_done();
    check_results("t4c", 0, 0, 0, 1, 0, 0);

    // 5: abort at pixel 10 with sof, then a full frame B
    @(posedge clk); #1;
    base = done_cnt;
    send_frame(KIND_B, 10);
    @(negedge clk);
    @(posedge clk); #1;
    arm_w = 1;
    send_frame(KIND_B, NPIX);
    wait_done();
    check_results("t5", 6, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    arm_w = 0;
    check("t5_done_once", 32'(done_cnt - base), 32'd1);

`ifdef MOTION_ROI_EN
    // 6a: row window 2..3 on frame B motion
    roi_y_min = 9'd0;
    roi_y_max = 9'd3;
    send_frame(KIND_A, NPIX);
    wait_done();
    roi_y_min = 9'd2;
    roi_y_max = 9'd3;
    send_frame(KIND_B, NPIX);
    wait_done();
    check_results("t6roi", 4, 2, 1, 0, 0, 0);
`endif

    // 6: asynchronous reset mid-SCAN, then primed must be clear again
    send_frame(KIND_A, 5);
    @(negedge clk);
    check("t6_busy_scan", 32'(busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_busy_wr", 32'({busy, fb_wr_en, fb_rd_en, frame_done}), 32'd0);
    check_results("t6_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    base = done_cnt;
    send_frame(KIND_A, NPIX);
    wait_done();
    check_results("t6_unprimed", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("t6_done_once", 32'(done_cnt - base), 32'd1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
